div16_seq_core: RTL
===================

// Module: div16_seq_core
// PURPOSE
//  Sequential unsigned restoring divider; the compute core behind the J1 divider peripheral.
//  Peripheral writes A (dividend) and B (divisor), then pulses init_in.
//  Core produces Result = A / B and Remainder = A % B after WIDTH shift-subtract steps.
//  Raises done (level) for the peripheral to poll; flags divide-by-zero.
// PARAMETERS
//  WIDTH     16   operand/result width in bits (>=2)
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      synchronous reset, ACTIVE-LOW (rst==0 resets on posedge clk)
//  init_in    in   1      start request; sampled only in IDLE or DONE
//  A          in   WIDTH  dividend, captured on accepted init_in
//  B          in   WIDTH  divisor, captured on accepted init_in
//  Result     out  WIDTH  quotient; stable while done==1
//  Remainder  out  WIDTH  remainder; stable while done==1
//  done       out  1      level: result valid; held until next accepted init_in or reset
//  busy       out  1      high during LOAD/SHIFT states
//  div_zero   out  1      B was 0 for the current result; valid with done
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; Result=0, Remainder=0, done=0, busy=0,
//   div_zero=0; internal count=0. Reset mid-operation aborts; no done is produced.
//  States: IDLE, LOAD, SHIFT, DONE.
//   IDLE : init_in==1 -> latch A,B; if B==0 -> DONE, else LOAD.
//   LOAD : rem=0, quo=A_lat, count=WIDTH-1, busy=1 -> SHIFT.
//   SHIFT: one step per cycle: {rem,quo} <<= 1; trial = rem' - B_lat (WIDTH+1 bits);
//          if trial non-negative: rem=trial[WIDTH-1:0], quo[0]=1; else quo[0]=0.
//          count==0 -> DONE; else count-1.
//   DONE : Result=quo, Remainder=rem, done=1, busy=0. init_in==1 -> same as IDLE
//          (done drops to 0 on the accepting edge; new operands latched).
//  Latency: init_in accepted at edge N -> done==1 after edge N+WIDTH+2 (18 cycles @16).
//  Divide-by-zero: done after edge N+1; Result={WIDTH{1'b1}}, Remainder=A, div_zero=1.
//  init_in while busy (LOAD/SHIFT): ignored; operands and progress unaffected.
//  init_in held high for several cycles in IDLE/DONE: each DONE cycle with init_in high
//   restarts; peripheral drives a single-cycle pulse, so this is legal but not expected.
//  A, B changes after acceptance have no effect (latched copies only).
//  Arithmetic: unsigned only; trial subtraction one bit wider than WIDTH to expose borrow;
//   quotient fits WIDTH for all inputs (max A/1 = 2^WIDTH-1).
//  Outputs Result/Remainder update only on entry to DONE; they hold last value otherwise.
// STRUCTURE
//  Shared header div_defs.vh: state encodings (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SHIFT=2'd2,
//   ST_DONE=2'd3) and DIV_WIDTH default; reused by the peripheral bench.
//  One sub-module: div_step (combinational shift+trial-subtract of one bit, WIDTH param);
//   FSM, counter and operand/result registers stay in div16_seq_core.
// TESTING
//  1. A=100, B=7, pulse init_in -> done high 18 cycles later, Result=14, Remainder=2, div_zero=0.
//  2. A=16'hFFFF, B=1 -> Result=16'hFFFF, Remainder=0; A=16'hFFFF,B=16'hFFFF -> 1, 0.
//  3. A=3, B=10 -> Result=0, Remainder=3; A=0, B=5 -> Result=0, Remainder=0.
//  4. A=5, B=0 -> done 2 cycles after init, Result=16'hFFFF, Remainder=5, div_zero=1.
//  5. Start 1000/3; pulse init_in with A=9,B=3 at step 5 -> ignored, Result=333, Rem=1.
//  6. Start 1000/3; drive rst=0 at step 8 -> all outputs 0 next edge, no done; restart 50/6 ->
//     Result=8, Remainder=2. Plus random unsigned A,B vs reference model, 10k operations.

Source files
------------

// File: rtl/div16_seq_core_pkg.sv
// Shared definitions for the sequential divider: state encodings,
// default operand width and the start-acceptance helper.
package div16_seq_core_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A start request is only honoured when no division is in flight.
  function automatic logic can_accept(input state_e st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/div16_seq_core_div_step.sv
// One restoring-division step: shift {rem,quo} left by one and try to
// subtract the divisor from the widened partial remainder.
module div16_seq_core_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] trial_s;
  logic             borrow_s;

  // Trial subtraction with headroom: the shifted remainder needs WIDTH+1 bits
  // and one more bit exposes the borrow. A non-negative trial is always below
  // the divisor, so either top bit set means the trial went negative.
  always_comb begin
    trial_s  = {1'b0, rem_i, quo_i[WIDTH-1]} - {2'b00, div_i};
    borrow_s = trial_s[WIDTH+1] | trial_s[WIDTH];
    if (borrow_s) begin
      rem_o = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div16_seq_core.sv
// Sequential unsigned restoring divider core. Latches A/B on an accepted
// start, runs WIDTH shift-subtract steps and holds the result with a
// level-type done until the next accepted start. Divide-by-zero skips the
// iteration and reports all-ones quotient with the dividend as remainder.
module div16_seq_core
  import div16_seq_core_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d, rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d, busy_q, busy_d, dzo_q, dzo_d;
  logic             accept_s;
  logic [WIDTH-1:0] step_rem_s, step_quo_s;

  div16_seq_core_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (b_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state, datapath and registered-output decisions.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    accept_s = init_in && can_accept(state_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          a_d = A;
          b_d = B;
          if (B == {WIDTH{1'b0}}) begin
            quo_d   = {WIDTH{1'b1}};
            rem_d   = A;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        rem_d   = {WIDTH{1'b0}};
        quo_d   = a_q;
        cnt_d   = CW'(WIDTH - 1);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results are republished only while resting in DONE; an accepting
    // edge drops done and leaves the previous values on the outputs.
    if ((state_q == ST_DONE) && !accept_s) begin
      done_d = 1'b1;
      res_d  = quo_q;
      rmd_d  = rem_q;
      dzo_d  = dz_q;
    end else begin
      done_d = 1'b0;
      res_d  = res_q;
      rmd_d  = rmd_q;
      dzo_d  = dzo_q;
    end
    busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
  end

  // State, operand and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      dz_q    <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      rmd_q   <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      rmd_q   <= rmd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dzo_q   <= dzo_d;
    end
  end

  assign Result    = res_q;
  assign Remainder = rmd_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign div_zero  = dzo_q;

endmodule
